// File: rtl/vga_sync_pkg.sv
// Shared 640x480@60Hz timing constants and coordinate type.
// The draw_* blocks import this package to get the screen bounds.
package vga_sync_pkg;
  typedef logic [9:0] coord_t;

  localparam int DEF_H_DISPLAY = 640;
  localparam int DEF_H_FP      = 16;
  localparam int DEF_H_SYNC    = 96;
  localparam int DEF_H_BP      = 48;
  localparam int DEF_V_DISPLAY = 480;
  localparam int DEF_V_FP      = 10;
  localparam int DEF_V_SYNC    = 2;
  localparam int DEF_V_BP      = 33;
  localparam int DEF_CLK_DIV   = 2;

  localparam int H_TOTAL  = DEF_H_DISPLAY + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int V_TOTAL  = DEF_V_DISPLAY + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int HS_START = DEF_H_DISPLAY + DEF_H_FP;
  localparam int HS_END   = HS_START + DEF_H_SYNC - 1;
  localparam int VS_START = DEF_V_DISPLAY + DEF_V_FP;
  localparam int VS_END   = VS_START + DEF_V_SYNC - 1;

  function automatic logic in_span(coord_t v, coord_t lo, coord_t hi);
    return (v >= lo) && (v <= hi);
  endfunction
endpackage

// File: rtl/vga_sync_if.sv
// Timing bundle from vga_sync to the pixel drawing blocks and RGB mux.
interface vga_sync_if;
  import vga_sync_pkg::*;
  coord_t opixel_x;
  coord_t opixel_y;
  logic   ovideo_on;
  logic   ohsync;
  logic   ovsync;
  logic   opixel_tick;
  logic   oframe_start;

  modport master (output opixel_x, opixel_y, ovideo_on, ohsync, ovsync, opixel_tick, oframe_start);
  modport slave  (input  opixel_x, opixel_y, ovideo_on, ohsync, ovsync, opixel_tick, oframe_start);
endinterface

// File: rtl/vga_sync_pixel_tick_gen.sv
// Pixel-rate enable: div_cnt wraps every CLK_DIV clocks, tick on the last count.
module pixel_tick_gen #(
  parameter int CLK_DIV = 2
) (
  input  logic iclk,
  input  logic irst_n,
  output logic otick
);
  localparam int CW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(CLK_DIV - 1);

  logic [CW-1:0] div_cnt;

  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n)              div_cnt <= '0;
    else if (div_cnt == LAST) div_cnt <= '0;
    else                      div_cnt <= div_cnt + 1'b1;
  end

  // Gating with reset keeps tick low in reset for CLK_DIV=1 and lets
  // the very first edge after release carry the tick.
  assign otick = irst_n && (div_cnt == LAST);
endmodule

// File: rtl/vga_sync.sv
// VGA timing generator: pixel/line counters with registered sync, video-active
// and frame-start outputs decoded from the next counter state.
module vga_sync
  import vga_sync_pkg::*;
#(
  parameter int H_DISPLAY = DEF_H_DISPLAY,
  parameter int H_FP      = DEF_H_FP,
  parameter int H_SYNC    = DEF_H_SYNC,
  parameter int H_BP      = DEF_H_BP,
  parameter int V_DISPLAY = DEF_V_DISPLAY,
  parameter int V_FP      = DEF_V_FP,
  parameter int V_SYNC    = DEF_V_SYNC,
  parameter int V_BP      = DEF_V_BP,
  parameter int CLK_DIV   = DEF_CLK_DIV
) (
  input  logic      iclk,
  input  logic      irst_n,
  vga_sync_if.master vga
);
  localparam coord_t X_MAX = coord_t'(H_DISPLAY + H_FP + H_SYNC + H_BP - 1);
  localparam coord_t Y_MAX = coord_t'(V_DISPLAY + V_FP + V_SYNC + V_BP - 1);
  localparam coord_t X_VIS = coord_t'(H_DISPLAY);
  localparam coord_t Y_VIS = coord_t'(V_DISPLAY);
  localparam coord_t HS_LO = coord_t'(H_DISPLAY + H_FP);
  localparam coord_t HS_HI = coord_t'(H_DISPLAY + H_FP + H_SYNC - 1);
  localparam coord_t VS_LO = coord_t'(V_DISPLAY + V_FP);
  localparam coord_t VS_HI = coord_t'(V_DISPLAY + V_FP + V_SYNC - 1);

  logic   tick;
  coord_t x, y, x_nxt, y_nxt;
  logic   video_on, hsync, vsync, frame_start;

  pixel_tick_gen #(.CLK_DIV(CLK_DIV)) u_tick (
    .iclk   (iclk),
    .irst_n (irst_n),
    .otick  (tick)
  );

  always_comb begin
    x_nxt = x;
    y_nxt = y;
    if (tick) begin
      if (x != X_MAX) begin
        x_nxt = x + coord_t'(1);
      end else begin
        x_nxt = '0;
        y_nxt = (y == Y_MAX) ? '0 : y + coord_t'(1);
      end
    end
  end

  // Reset parks the counters on the last pixel so the first tick wraps to (0,0).
  always_ff @(posedge iclk or negedge irst_n) begin
    if (!irst_n) begin
      x           <= X_MAX;
      y           <= Y_MAX;
      video_on    <= 1'b0;
      hsync       <= 1'b1;
      vsync       <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      x           <= x_nxt;
      y           <= y_nxt;
      video_on    <= (x_nxt < X_VIS) && (y_nxt < Y_VIS);
      hsync       <= !in_span(x_nxt, HS_LO, HS_HI);
      vsync       <= !in_span(y_nxt, VS_LO, VS_HI);
      frame_start <= tick && (x_nxt == '0) && (y_nxt == '0);
    end
  end

  assign vga.opixel_x     = x;
  assign vga.opixel_y     = y;
  assign vga.ovideo_on    = video_on;
  assign vga.ohsync       = hsync;
  assign vga.ovsync       = vsync;
  assign vga.opixel_tick  = tick;
  assign vga.oframe_start = frame_start;
endmodule
